id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 6, control-bit width (mem_read, mem_write, wb_en, imm, branch_taken, status_we).
REQ-002 SHALL have parameter DATA_W, default 128, datapath payload width (PC, operands, dest, imm, shift operand, exec command).
REQ-003 SHALL have parameter STAT_W, default 4, status-flag width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  discard all held and incoming instructions (branch taken).
REQ-008 in_valid  in  1  ID stage presents an instruction.
REQ-009 in_ready  out  1  block accepts the instruction this cycle.
REQ-010 in_ctrl / in_data / in_stat  in  CTRL_W / DATA_W / STAT_W  instruction fields.
REQ-011 out_valid  out  1  EX stage instruction valid.
REQ-012 out_ready  in  1  EX stage consumes the instruction this cycle.
REQ-013 out_ctrl / out_data / out_stat  out  CTRL_W / DATA_W / STAT_W  registered fields.
REQ-014 stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 Input transfer SHALL occur iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-016 Latency SHALL be exactly one cycle from input transfer to out_valid when the output register is empty.
REQ-017 out_ctrl SHALL be all-zero whenever out_valid is 0 (bubble is a NOP; no write-back, memory or status effect).
REQ-018 Without skid, in_ready SHALL equal !out_valid || out_ready (combinational pass-through).
REQ-019 Held output fields SHALL remain stable while out_valid && !out_ready.
REQ-020 Simultaneous output and input transfer SHALL replace the output register with the new instruction, no bubble.
REQ-021 flush SHALL, on the next edge, clear out_valid, out_ctrl and any skid entry, and drop any same-cycle input transfer; out_data/out_stat need not be cleared.
REQ-022 flush SHALL take priority over in_valid, out_ready and all other updates except rst.
REQ-023 stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready, saturate at 2^CNT_W-1, never wrap, and be unaffected by flush.

Reset
REQ-024 On rst: out_valid=0, out_ctrl=0, out_data=0, out_stat=0, skid empty, stall_cnt=0.
REQ-025 rst asserted mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro ID_EX_SKID_EN SHALL add a one-entry skid buffer.
REQ-027 With ID_EX_SKID_EN: in_ready SHALL be a register equal to "skid empty", with no combinational path from out_ready; an input accepted while output stalls SHALL go to skid and be presented after the held instruction, in order.
REQ-028 With ID_EX_SKID_EN: skid full SHALL force in_ready=0 next cycle; output transfer with skid full SHALL move skid to output and free skid.
REQ-029 Without ID_EX_SKID_EN: behaviour per REQ-018, no skid storage synthesised.

Structure
REQ-030 CTRL_W bit positions (MEM_R, MEM_W, WB_EN, IMM, BR, S_WE) and default widths SHALL live in the shared defines package alongside existing length macros.
REQ-031 Skid storage SHALL be a sub-module id_ex_skid_slot (valid+ctrl+data+stat register); no other sub-modules.

Verification
REQ-032 rst then in_valid=1, in_ctrl=6'b000100, out_ready=1 -> out_valid=1, out_ctrl=6'b000100 one cycle later.
REQ-033 Hold out_ready=0 for 5 cycles with out_valid=1 -> fields stable, stall_cnt=5; no-skid in_ready=0.
REQ-034 flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, input dropped, stall_cnt unchanged.
REQ-035 CNT_W=4, stall 20 cycles -> stall_cnt sticks at 15.
REQ-036 ID_EX_SKID_EN, out_ready=0, send A,B -> A held, B in skid, in_ready=0; out_ready=1 -> A then B on consecutive cycles, in_ready=1 again.
REQ-037 rst during stall with skid full -> out_valid=0, skid empty, stall_cnt=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths and control-bit positions for the ID/EX pipeline register.
package id_ex_pipe_reg_pkg;

  localparam int unsigned CTRL_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned STAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bit positions within the control field
  localparam int unsigned CTRL_MEM_R = 0;
  localparam int unsigned CTRL_MEM_W = 1;
  localparam int unsigned CTRL_WB_EN = 2;
  localparam int unsigned CTRL_IMM   = 3;
  localparam int unsigned CTRL_BR    = 4;
  localparam int unsigned CTRL_S_WE  = 5;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Valid/ready instruction bus between ID (master) and EX register (slave).
interface id_ex_pipe_reg_if
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [STAT_W-1:0] in_stat;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [STAT_W-1:0] out_stat;

  modport master (
    output in_valid, in_ctrl, in_data, in_stat, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_stat
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_stat, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_stat
  );
endinterface

// File: rtl/id_ex_skid_slot.sv
// One-entry skid register (valid + ctrl + data + stat); clr drops the entry.
module id_ex_skid_slot
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [STAT_W-1:0] in_stat,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [STAT_W-1:0] stat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      stat  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
      stat  <= in_stat;
    end else if (unload) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, NOP bubbles and a saturating stall counter.
// Define ID_EX_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_pipe_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_data_q;
  logic [STAT_W-1:0] out_stat_q;

  logic              nxt_valid;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [DATA_W-1:0] nxt_data;
  logic [STAT_W-1:0] nxt_stat;

  logic out_xfer;
  logic in_xfer;
  logic stalled;

  assign stalled  = out_valid_q && !bus.out_ready;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign in_xfer  = bus.in_valid && bus.in_ready;

`ifdef ID_EX_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [STAT_W-1:0] skid_stat;
  logic              skid_load;
  logic              skid_unload;

  // Accepts parked while the output stalls; skid drains first once it moves
  assign skid_load   = in_xfer && stalled;
  assign skid_unload = skid_valid && !stalled;

  id_ex_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .STAT_W (STAT_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .load    (skid_load),
    .unload  (skid_unload),
    .in_ctrl (bus.in_ctrl),
    .in_data (bus.in_data),
    .in_stat (bus.in_stat),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data),
    .stat    (skid_stat)
  );

  assign bus.in_ready = !skid_valid;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  // Output register next state; flush wins, an empty/draining slot refills
  always_comb begin
    nxt_valid = out_valid_q;
    nxt_ctrl  = out_ctrl_q;
    nxt_data  = out_data_q;
    nxt_stat  = out_stat_q;
    if (flush) begin
      nxt_valid = 1'b0;
      nxt_ctrl  = '0;
`ifdef ID_EX_SKID_EN
    end else if (skid_unload) begin
      nxt_valid = 1'b1;
      nxt_ctrl  = skid_ctrl;
      nxt_data  = skid_data;
      nxt_stat  = skid_stat;
`endif
    end else if (in_xfer && !stalled) begin
      nxt_valid = 1'b1;
      nxt_ctrl  = bus.in_ctrl;
      nxt_data  = bus.in_data;
      nxt_stat  = bus.in_stat;
    end else if (out_xfer) begin
      nxt_valid = 1'b0;
      nxt_ctrl  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      out_stat_q  <= '0;
      stall_cnt   <= '0;
    end else begin
      out_valid_q <= nxt_valid;
      out_ctrl_q  <= nxt_ctrl;
      out_data_q  <= nxt_data;
      out_stat_q  <= nxt_stat;
      if (stalled && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_stat  = out_stat_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; the skid sequence runs when ID_EX_SKID_EN is defined.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [5:0]   ctrl;
    logic [127:0] data;
    logic [3:0]   stat;
  } item_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 0;
  item_t q[$];

  id_ex_pipe_reg_if bus ();
  id_ex_pipe_reg_if bus4 ();

  id_ex_pipe_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation
  id_ex_pipe_reg #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus4.slave),
    .stall_cnt (stall_cnt4)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_ctrl   = bus.in_ctrl;
  assign bus4.in_data   = bus.in_data;
  assign bus4.in_stat   = bus.in_stat;
  assign bus4.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Present an instruction; acc is the hand-derived in_ready for this cycle
  task automatic send(input logic [5:0] c, input logic [127:0] d, input logic [3:0] s, input bit acc);
    item_t it;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_data  = d;
    bus.in_stat  = s;
    #1;
    chk("in_ready_on_send", 128'(bus.in_ready), 128'(acc));
    if (acc) begin
      it.ctrl = c;
      it.data = d;
      it.stat = s;
      q.push_back(it);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
  endtask

  // Monitor: every output transfer must match the next scoreboard entry
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: got ctrl %0h data %0h with empty scoreboard", bus.out_ctrl, bus.out_data);
        end else begin
          item_t e;
          e = q.pop_front();
          chk("out_ctrl", 128'(bus.out_ctrl), 128'(e.ctrl));
          chk("out_data", bus.out_data, e.data);
          chk("out_stat", 128'(bus.out_stat), 128'(e.stat));
        end
      end
      if (!bus.out_valid) chk("bubble_ctrl_zero", 128'(bus.out_ctrl), 128'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.in_stat   = '0;
    bus.out_ready = 1'b0;
    do_reset();

    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_out_stat", 128'(bus.out_stat), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    mon_en = 1'b1;

`ifdef ID_EX_SKID_EN
    // A held, B parked in skid, then both drain in order
    bus.out_ready = 1'b0;
    send(6'h11, 128'hA0A0, 4'hA, 1'b1);
    cyc();
    send(6'h22, 128'hB0B0, 4'hB, 1'b1);
    cyc();
    idle();
    chk("skid_full_in_ready", 128'(bus.in_ready), 128'(0));
    chk("skid_held_ctrl", 128'(bus.out_ctrl), 128'(6'h11));
    chk("skid_stall_cnt", 128'(stall_cnt), 128'(1));
    bus.out_ready = 1'b1;
    cyc();
    chk("skid_b_ctrl", 128'(bus.out_ctrl), 128'(6'h22));
    chk("skid_b_valid", 128'(bus.out_valid), 128'(1));
    chk("skid_free_in_ready", 128'(bus.in_ready), 128'(1));
    cyc();
    chk("skid_drained_valid", 128'(bus.out_valid), 128'(0));

    // Reset with output held and skid full
    bus.out_ready = 1'b0;
    send(6'h33, 128'hC0C0, 4'hC, 1'b1);
    cyc();
    send(6'h34, 128'hD0D0, 4'hD, 1'b1);
    cyc();
    idle();
    chk("skid2_full_in_ready", 128'(bus.in_ready), 128'(0));
    rst = 1'b1;
    void'(q.pop_back());
    void'(q.pop_back());
    cyc();
    rst = 1'b0;
    #1;
    chk("skid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("skid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("skid_rst_stall_cnt", 128'(stall_cnt), 128'(0));
    bus.out_ready = 1'b1;
    cyc();
    chk("skid_rst_no_replay", 128'(bus.out_valid), 128'(0));
`else
    // Single instruction, one-cycle latency
    bus.out_ready = 1'b1;
    send(6'b000100, 128'h1111_2222_3333_4444, 4'h1, 1'b1);
    cyc();
    idle();
    chk("lat_out_valid", 128'(bus.out_valid), 128'(1));
    chk("lat_out_ctrl", 128'(bus.out_ctrl), 128'(6'b000100));
    cyc();
    chk("after_consume_valid", 128'(bus.out_valid), 128'(0));

    // Back-to-back transfers, no bubbles
    for (int i = 0; i < 3; i++) begin
      send(6'(i + 8), 128'(64'hCAFE_0000 + i), 4'(i + 2), 1'b1);
      cyc();
      chk("b2b_out_valid", 128'(bus.out_valid), 128'(1));
    end
    idle();
    cyc();
    chk("b2b_drained", 128'(bus.out_valid), 128'(0));

    // Five-cycle stall: fields held, in_ready low, counter counts
    bus.out_ready = 1'b0;
    send(6'h2A, 128'hEEEE, 4'hE, 1'b1);
    cyc();
    send(6'h15, 128'hFFFF, 4'hF, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("stall_ctrl_stable", 128'(bus.out_ctrl), 128'(6'h2A));
      chk("stall_data_stable", bus.out_data, 128'hEEEE);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
    end
    chk("stall_cnt_5", 128'(stall_cnt), 128'(5));
    bus.out_ready = 1'b1;
    send(6'h15, 128'hFFFF, 4'hF, 1'b1);
    cyc();
    chk("replace_ctrl", 128'(bus.out_ctrl), 128'(6'h15));
    chk("replace_stall_cnt", 128'(stall_cnt), 128'(5));

    // Flush with held and incoming instructions
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 6'h3F;
    bus.in_data   = 128'h6666;
    cyc();
    flush = 1'b0;
    idle();
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("flush_stall_cnt", 128'(stall_cnt), 128'(5));
    cyc();
    chk("flush_input_dropped", 128'(bus.out_valid), 128'(0));

    // Flush of a stalled instruction; counter still advances
    bus.out_ready = 1'b0;
    send(6'h07, 128'h7777, 4'h7, 1'b1);
    cyc();
    idle();
    cyc();
    chk("stall_cnt_6", 128'(stall_cnt), 128'(6));
    flush = 1'b1;
    void'(q.pop_back());
    cyc();
    flush = 1'b0;
    chk("flush_stall_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_stall_cnt_7", 128'(stall_cnt), 128'(7));

    // Long stall: 4-bit counter saturates at 15
    send(6'h09, 128'h9999, 4'h9, 1'b1);
    cyc();
    idle();
    repeat (8) cyc();
    chk("sat4_reach", 128'(stall_cnt4), 128'(15));
    chk("cnt16_15", 128'(stall_cnt), 128'(15));
    repeat (12) cyc();
    chk("sat4_stick", 128'(stall_cnt4), 128'(15));
    chk("cnt16_27", 128'(stall_cnt), 128'(27));
    chk("sat_ctrl_held", 128'(bus.out_ctrl), 128'(6'h09));

    // Reset mid-stall discards the held instruction
    rst = 1'b1;
    void'(q.pop_back());
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_out_data", bus.out_data, 128'(0));
    chk("mid_rst_stall_cnt", 128'(stall_cnt), 128'(0));
    chk("mid_rst_stall_cnt4", 128'(stall_cnt4), 128'(0));
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));

    bus.out_ready = 1'b1;
    send(6'h01, 128'h0123_4567_89AB_CDEF, 4'h5, 1'b1);
    cyc();
    idle();
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    cyc();
    chk("scoreboard_drained", 128'(q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
